// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, frame size and command bytes for the PS/2 host path
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_state_t;

    localparam int FRAME_BITS = 10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer, 4-sample glitch filter and fall detector for one PS/2 line
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_clrn,
    input  logic i_line,
    output logic o_filt,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [3:0] r_hist;
    logic       r_filt;
    logic       r_filt_d;

    // Idle PS/2 lines float high, so everything resets to 1 to avoid a spurious fall.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_sync   <= 2'b11;
            r_hist   <= 4'hF;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], i_line};
            r_hist   <= {r_hist[2:0], r_sync[1]};
            if (r_hist == 4'hF) begin
                r_filt <= 1'b1;
            end else if (r_hist == 4'h0) begin
                r_filt <= 1'b0;
            end
            r_filt_d <= r_filt;
        end
    end

    assign o_filt = r_filt;
    assign o_fall = r_filt_d & ~r_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with open-drain line control
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       i_clk,
    input  logic       i_clrn,
    input  logic       i_wr,
    input  logic [7:0] i_din,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_drv,
    output logic       o_ps2_data_drv,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_rx_inhibit
);

    localparam int MAX_A = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int CNT_W = $clog2(MAX_CNT + 1);

    ps2_state_t                r_state;
    ps2_state_t                w_next_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [3:0]                r_bit;
    logic [FRAME_BITS-1:0]     r_frame;
    logic                      r_data_drv;
    logic [1:0]                r_data_sync;
    logic                      w_clk_filt;
    logic                      w_clk_fall;
    logic                      w_data;
    logic                      w_timeout;

    ps2_line_sync u_clk_sync (
        .i_clk  (i_clk),
        .i_clrn (i_clrn),
        .i_line (i_ps2_clk_in),
        .o_filt (w_clk_filt),
        .o_fall (w_clk_fall)
    );

    assign w_data    = r_data_sync[1];
    assign w_timeout = (r_state inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE})
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (i_wr) w_next_state = ST_INHIBIT;
            ST_INHIBIT:   if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) w_next_state = ST_START;
            ST_START:     if (r_cnt == CNT_W'(START_HOLD_CYCLES - 1)) w_next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (w_timeout) w_next_state = ST_ERR;
                else if (w_clk_fall && r_bit == 4'(FRAME_BITS - 1)) w_next_state = ST_ACK;
            end
            ST_ACK: begin
                if (w_timeout) w_next_state = ST_ERR;
                else if (w_clk_fall) w_next_state = w_data ? ST_ERR : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (w_timeout) w_next_state = ST_ERR;
                else if (w_clk_filt && w_data) w_next_state = ST_DONE;
            end
            ST_DONE:      w_next_state = ST_IDLE;
            ST_ERR:       w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ps2_clk_drv  = 1'b0;
        o_ps2_data_drv = r_data_drv;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        o_err          = 1'b0;
        if (r_state inside {ST_INHIBIT, ST_START}) o_ps2_clk_drv = 1'b1;
        if (!(r_state inside {ST_IDLE, ST_DONE, ST_ERR})) o_busy = 1'b1;
        if (r_state == ST_DONE) o_done = 1'b1;
        if (r_state == ST_ERR) o_err = 1'b1;
        o_rx_inhibit = o_busy;
    end

    // One counter serves inhibit, start hold and the frame timeout; it keeps running
    // across SHIFT -> ACK -> WAIT_IDLE so the timeout spans the whole frame.
    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_frame     <= '0;
            r_data_drv  <= 1'b0;
            r_data_sync <= 2'b11;
        end else begin
            r_data_sync <= {r_data_sync[0], i_ps2_data_in};

            if (w_next_state != r_state && (w_next_state inside {ST_INHIBIT, ST_START, ST_SHIFT})) begin
                r_cnt <= '0;
            end else if (r_state inside {ST_INHIBIT, ST_START, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == ST_IDLE && i_wr) begin
                r_frame <= {1'b1, odd_parity(i_din), i_din};
            end

            if (r_state == ST_START) begin
                r_bit <= '0;
            end

            if (r_state == ST_INHIBIT && w_next_state == ST_START) begin
                r_data_drv <= 1'b1;
            end else if (w_next_state inside {ST_IDLE, ST_DONE, ST_ERR}) begin
                r_data_drv <= 1'b0;
            end else if (r_state == ST_SHIFT && w_clk_fall) begin
                r_data_drv <= ~r_frame[0];
                r_frame    <= r_frame >> 1;
                r_bit      <= r_bit + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 5000;
    localparam int SH  = 50;
    localparam int TO  = 3000;
    localparam int H   = 50;

    typedef struct {
        logic [7:0] d;
        int         mode;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_drv, data_drv, busy, done, err, rx_inh;
    wire        line_clk  = ~(clk_drv | dev_clk_low);
    wire        line_data = ~(data_drv | dev_data_low);

    int    cyc = 0;
    int    n_done = 0;
    int    n_err = 0;
    int    n_inh_bad = 0;
    int    checks = 0;
    int    failures = 0;
    string cur = "init";

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_HOLD_CYCLES (SH),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .i_clk          (clk),
        .i_clrn         (clrn),
        .i_wr           (wr),
        .i_din          (din),
        .i_ps2_clk_in   (line_clk),
        .i_ps2_data_in  (line_data),
        .o_ps2_clk_drv  (clk_drv),
        .o_ps2_data_drv (data_drv),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_rx_inhibit   (rx_inh)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (err) n_err <= n_err + 1;
        if (rx_inh !== busy) n_inh_bad <= n_inh_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device side of one frame. mode: 0 ack, 1 no ack, 2 stop clocking after 4 bits, 3 reset mid-shift.
    task automatic run_frame(input logic [7:0] d, input int mode, input int exp_done,
                             input int exp_err, output logic [9:0] got);
        int t_inh, t_start, t_rel, k, d0, e0, i0;
        got = '0;
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh_bad;
        wr = 1'b1;
        din = d;
        tick(1);
        wr = 1'b0;
        t_inh = cyc;
        check("inhibit_entry", 32'({clk_drv, data_drv, busy}), 32'b101);
        k = 0;
        while (!data_drv && k < INH + 100) begin tick(1); k++; end
        t_start = cyc;
        check("inhibit_len", 32'(t_start - t_inh), 32'(INH));
        k = 0;
        while (clk_drv && k < SH + 100) begin tick(1); k++; end
        t_rel = cyc;
        check("start_hold_len", 32'(t_rel - t_start), 32'(SH));
        tick(20);
        check("start_bit_low", 32'(line_data), 32'd0);
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (mode == 2 && i == 4) break;
            if (mode == 3 && i == 3) break;
            dev_clk_low = 1'b1;
            tick(H);
            dev_clk_low = 1'b0;
            got[i] = line_data;
            tick(H);
        end
        if (mode < 2) begin
            dev_data_low = (mode == 0);
            dev_clk_low = 1'b1;
            tick(H);
            dev_clk_low = 1'b0;
            tick(5);
            dev_data_low = 1'b0;
            k = 0;
            while (busy && k < 1000) begin tick(1); k++; end
            check("busy_drop", 32'(busy), 32'd0);
        end else if (mode == 2) begin
            tick(10);
            wr = 1'b1;
            din = 8'h00;
            tick(1);
            wr = 1'b0;
            k = 0;
            while (!err && k < TO + 200) begin tick(1); k++; end
            check("timeout_latency", 32'(cyc - t_rel), 32'(TO));
            tick(5);
            check("wr_while_busy_ignored", 32'({busy, clk_drv, data_drv}), 32'd0);
        end else begin
            check("pre_reset_drive", 32'({busy, data_drv}), 32'b11);
            #3 clrn = 1'b0;
            #1;
            check("reset_mid_shift", 32'({busy, clk_drv, data_drv, done, err, rx_inh}), 32'd0);
            tick(2);
            clrn = 1'b1;
        end
        tick(3);
        check("done_count", 32'(n_done - d0), 32'(exp_done));
        check("err_count", 32'(n_err - e0), 32'(exp_err));
        check("rx_inhibit_tracks_busy", 32'(n_inh_bad - i0), 32'd0);
        check("lines_released", 32'({clk_drv, data_drv}), 32'd0);
    endtask

    vec_t       vecs[4];
    logic [9:0] got;

    initial begin
        vecs[0] = '{d: CMD_SET_LED, mode: 0, exp_bits: 10'h3ED, exp_done: 1, exp_err: 0};
        vecs[1] = '{d: CMD_ENABLE,  mode: 0, exp_bits: 10'h2F4, exp_done: 1, exp_err: 0};
        vecs[2] = '{d: 8'hA5,       mode: 1, exp_bits: 10'h3A5, exp_done: 0, exp_err: 1};
        vecs[3] = '{d: 8'h01,       mode: 0, exp_bits: 10'h201, exp_done: 1, exp_err: 0};

        clrn = 1'b0;
        wr = 1'b1;
        din = CMD_SET_LED;
        tick(3);
        cur = "reset";
        check("reset_outputs", 32'({clk_drv, data_drv, busy, done, err, rx_inh}), 32'd0);
        wr = 1'b0;
        tick(1);
        clrn = 1'b1;
        tick(3);
        check("idle_after_reset", 32'({clk_drv, data_drv, busy, done, err, rx_inh}), 32'd0);

        for (int v = 0; v < 4; v++) begin
            cur = $sformatf("vec%0d", v);
            run_frame(vecs[v].d, vecs[v].mode, vecs[v].exp_done, vecs[v].exp_err, got);
            check("frame_bits", 32'(got), 32'(vecs[v].exp_bits));
        end

        cur = "timeout";
        run_frame(8'h3C, 2, 0, 1, got);

        cur = "reset_mid";
        run_frame(8'h00, 3, 0, 0, got);
        cur = "after_reset";
        run_frame(CMD_RESET, 0, 1, 0, got);
        check("frame_bits", 32'(got), 32'h3FF);

        for (int r = 0; r < 3; r++) begin
            logic [7:0] d;
            int         m;
            logic [9:0] exp;
            d = 8'($urandom_range(0, 255));
            m = int'($urandom_range(0, 1));
            exp = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
            cur = $sformatf("rand%0d_%02h", r, d);
            run_frame(d, m, (m == 0) ? 1 : 0, (m == 1) ? 1 : 0, got);
            check("frame_bits", 32'(got), 32'(exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
